// File: rtl/alimentador_sesgado_2dmesh_pkg.sv
// Shared definitions for the skewed operand feeder: FSM states and the N/W defaults
// that match the 2D-mesh multiplier.
package alimentador_sesgado_2dmesh_pkg;

  localparam int N_DEF   = 2;
  localparam int W_DEF   = 4;
  localparam int TMO_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // Index width for an n-entry dimension, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alimentador_sesgado_2dmesh_if.sv
// Host load port and mesh handshake of the feeder. The slave modport is the feeder side;
// the master modport is the host/mesh side.
interface alimentador_sesgado_2dmesh_if
  import alimentador_sesgado_2dmesh_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) ();

  localparam int IW = idx_w(N);

  logic            i_ld;
  logic            i_lsel;
  logic [IW-1:0]   i_lrow;
  logic [IW-1:0]   i_lcol;
  logic [W-1:0]    i_ldat;
  logic            i_go;
  logic            i_eom;
  logic            o_stm;
  logic [N*W-1:0]  o_aout;
  logic [N*W-1:0]  o_bout;
  logic            o_busy;
  logic            o_done;
  logic            o_err;

  modport master (
    output i_ld, i_lsel, i_lrow, i_lcol, i_ldat, i_go, i_eom,
    input  o_stm, o_aout, o_bout, o_busy, o_done, o_err
  );

  modport slave (
    input  i_ld, i_lsel, i_lrow, i_lcol, i_ldat, i_go, i_eom,
    output o_stm, o_aout, o_bout, o_busy, o_done, o_err
  );

endinterface

// File: rtl/alimentador_sesgado_2dmesh_skew_lane.sv
// One skewed edge lane: element (beat - IDX) of an N-element vector, or 0 outside the
// lane's active window.
module alimentador_sesgado_2dmesh_skew_lane
  import alimentador_sesgado_2dmesh_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int BW  = 2,
  parameter int IDX = 0
) (
  input  logic [N*W-1:0] i_vec,
  input  logic [BW-1:0]  i_beat,
  input  logic           i_valid,
  output logic [W-1:0]   o_lane
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    o_lane = '0;
    for (int k = 0; k < N; k++) begin
      if (i_valid && (int'(i_beat) == IDX + k)) o_lane = i_vec[k*W +: W];
    end
  end

endmodule

// File: rtl/alimentador_sesgado_2dmesh.sv
// Skewed operand feeder for the 2D-mesh multiplier: loads A/B, pulses STM, streams skewed
// edges, waits for EOM. FEEDER_TIMEOUT_EN adds a WAIT watchdog that raises a sticky ERR.
module alimentador_sesgado_2dmesh
  import alimentador_sesgado_2dmesh_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
`ifdef FEEDER_TIMEOUT_EN
  , parameter int TMO = TMO_DEF
`endif
) (
  input logic                         i_clk,
  input logic                         i_rst,
  alimentador_sesgado_2dmesh_if.slave bus
);

  localparam int            BW        = $clog2(2*N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(2*N-2);

  state_t         r_state, w_state_nxt;
  logic [BW-1:0]  r_beat, w_beat_nxt;
  logic [W-1:0]   r_a [N][N];
  logic [W-1:0]   r_b [N][N];
  logic [N*W-1:0] w_a_row [N];
  logic [N*W-1:0] w_b_col [N];
  logic [N*W-1:0] w_a_lanes, w_b_lanes;
  logic           w_stream_nxt, w_stm_nxt, w_busy_nxt, w_done_nxt;
  logic           r_stm, r_busy, r_done;
  logic [N*W-1:0] r_aout, r_bout;
  logic           w_timeout;

`ifdef FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TMO+1);
  logic [CW-1:0] r_wcnt;
  logic          r_err;
`endif

  // Coefficient storage; writable only in IDLE so operands stay frozen during a run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: storage is a reset register file, not a RAM: a reset must clear every coefficient.
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
      end
    end else if (r_state == ST_IDLE && bus.i_ld) begin
      if (bus.i_lsel) r_b[bus.i_lrow][bus.i_lcol] <= bus.i_ldat;
      else            r_a[bus.i_lrow][bus.i_lcol] <= bus.i_ldat;
    end
  end

  // Row i of A and column j of B, element k at bits k*W.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_row[i] = '0;
      w_b_col[i] = '0;
      for (int k = 0; k < N; k++) begin
        w_a_row[i][k*W +: W] = r_a[i][k];
        w_b_col[i][k*W +: W] = r_b[k][i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    alimentador_sesgado_2dmesh_skew_lane #(.N(N), .W(W), .BW(BW), .IDX(g)) u_a_lane (
      .i_vec   (w_a_row[g]),
      .i_beat  (w_beat_nxt),
      .i_valid (w_stream_nxt),
      .o_lane  (w_a_lanes[g*W +: W])
    );
    alimentador_sesgado_2dmesh_skew_lane #(.N(N), .W(W), .BW(BW), .IDX(g)) u_b_lane (
      .i_vec   (w_b_col[g]),
      .i_beat  (w_beat_nxt),
      .i_valid (w_stream_nxt),
      .o_lane  (w_b_lanes[g*W +: W])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    unique case (r_state)
      ST_IDLE:   if (bus.i_go) w_state_nxt = ST_START;
      ST_START: begin
        w_state_nxt = ST_STREAM;
        w_beat_nxt  = '0;
      end
      ST_STREAM: begin
        if (r_beat == LAST_BEAT) begin
          w_state_nxt = ST_WAIT;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt  = r_beat + BW'(1);
        end
      end
      ST_WAIT:   if (bus.i_eom || w_timeout) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decided from the next state so the registered lanes line up with the beat.
  always_comb begin
    w_stream_nxt = (w_state_nxt == ST_STREAM);
    w_stm_nxt    = (w_state_nxt == ST_START);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_done_nxt   = (r_state == ST_WAIT) && (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stm  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_aout <= '0;
      r_bout <= '0;
    end else begin
      r_stm  <= w_stm_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_aout <= w_a_lanes;
      r_bout <= w_b_lanes;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  // Watchdog: r_wcnt holds the number of completed WAIT cycles; the TMO-th one times out.
  assign w_timeout = (r_state == ST_WAIT) && !bus.i_eom && (r_wcnt == CW'(TMO-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= (r_state == ST_WAIT) ? r_wcnt + CW'(1) : '0;
      if (r_state == ST_IDLE && bus.i_go) r_err <= 1'b0;
      else if (w_timeout)                 r_err <= 1'b1;
    end
  end

  assign bus.o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_stm  = r_stm;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_aout = r_aout;
  assign bus.o_bout = r_bout;

endmodule

// File: tb/tb_alimentador_sesgado_2dmesh.sv
// Self-checking bench for alimentador_sesgado_2dmesh: table of matrix pairs plus hand-written
// sequences for reset, frozen storage, ignored GO/EOM and (with FEEDER_TIMEOUT_EN) the watchdog.
module tb_alimentador_sesgado_2dmesh;
  import alimentador_sesgado_2dmesh_pkg::*;

  localparam int N  = N_DEF;
  localparam int W  = W_DEF;
  localparam int IW = idx_w(N);
  localparam int NB = 2*N-1;
  localparam int LW = N*W;
  localparam int MW = N*N*W;
  localparam int NV = 6;

  typedef struct packed {
    logic [MW-1:0]    a;
    logic [MW-1:0]    b;
    logic [NB*LW-1:0] exp_a;
    logic [NB*LW-1:0] exp_b;
    logic [3:0]       eom_gap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic exp_err = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  alimentador_sesgado_2dmesh_if #(.N(N), .W(W)) bus ();

  alimentador_sesgado_2dmesh #(.N(N), .W(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference model: matrix element (r,c) sits at bits (r*N+c)*W of a flat word.
  function automatic logic [LW-1:0] model_a(input logic [MW-1:0] m, input int t);
    logic [LW-1:0] lanes = '0;
    for (int i = 0; i < N; i++) begin
      int c = t - i;
      if (c >= 0 && c < N) lanes[i*W +: W] = m[(i*N+c)*W +: W];
    end
    return lanes;
  endfunction

  function automatic logic [LW-1:0] model_b(input logic [MW-1:0] m, input int t);
    logic [LW-1:0] lanes = '0;
    for (int j = 0; j < N; j++) begin
      int r = t - j;
      if (r >= 0 && r < N) lanes[j*W +: W] = m[(r*N+j)*W +: W];
    end
    return lanes;
  endfunction

  function automatic logic [NB*LW-1:0] pack_a(input logic [MW-1:0] m);
    logic [NB*LW-1:0] v = '0;
    for (int t = 0; t < NB; t++) v[t*LW +: LW] = model_a(m, t);
    return v;
  endfunction

  function automatic logic [NB*LW-1:0] pack_b(input logic [MW-1:0] m);
    logic [NB*LW-1:0] v = '0;
    for (int t = 0; t < NB; t++) v[t*LW +: LW] = model_b(m, t);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {stm, busy, done, err, aout, bout} in one shot.
  task automatic expect_outs(input string name, input logic stm, input logic busy,
                             input logic done, input logic [LW-1:0] a, input logic [LW-1:0] b);
    check(name, {bus.o_stm, bus.o_busy, bus.o_done, bus.o_err, bus.o_aout, bus.o_bout},
          {stm, busy, done, exp_err, a, b});
  endtask

  task automatic load_word(input logic sel, input int r, input int c, input logic [W-1:0] val);
    bus.i_ld   = 1'b1;
    bus.i_lsel = sel;
    bus.i_lrow = IW'(r);
    bus.i_lcol = IW'(c);
    bus.i_ldat = val;
    tick();
    bus.i_ld   = 1'b0;
  endtask

  task automatic load_mats(input logic [MW-1:0] a, input logic [MW-1:0] b);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        load_word(1'b0, r, c, a[(r*N+c)*W +: W]);
        load_word(1'b1, r, c, b[(r*N+c)*W +: W]);
      end
    end
  endtask

  // GO, then check the STM cycle and every beat; returns in the last-beat cycle.
  task automatic run_stream(input string name, input logic [NB*LW-1:0] ea,
                            input logic [NB*LW-1:0] eb);
    bus.i_go = 1'b1;
    tick();
    bus.i_go = 1'b0;
    bus.i_ld = 1'b0;
    expect_outs({name, ".start"}, 1'b1, 1'b1, 1'b0, '0, '0);
    for (int t = 0; t < NB; t++) begin
      tick();
      expect_outs($sformatf("%s.beat%0d", name, t), 1'b0, 1'b1, 1'b0,
                  ea[t*LW +: LW], eb[t*LW +: LW]);
    end
  endtask

  // EOM is presented gap cycles after the last beat; DONE shows on the following cycle.
  task automatic finish_with_eom(input string name, input int gap);
    for (int k = 1; k <= gap; k++) begin
      tick();
      expect_outs($sformatf("%s.wait%0d", name, k), 1'b0, 1'b1, 1'b0, '0, '0);
    end
    bus.i_eom = 1'b1;
    tick();
    bus.i_eom = 1'b0;
    expect_outs({name, ".done"}, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    expect_outs({name, ".idle"}, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [MW-1:0]    spec_a = 16'h4321;
    logic [MW-1:0]    spec_b = 16'h8765;
    logic [MW-1:0]    b_mod;
    logic [31:0]      rnd;

    bus.i_ld = 1'b0; bus.i_lsel = 1'b0; bus.i_lrow = '0; bus.i_lcol = '0;
    bus.i_ldat = '0; bus.i_eom = 1'b0;

    // Reset held two cycles with GO high: GO must not start a run.
    rst = 1'b1;
    bus.i_go = 1'b1;
    tick();
    tick();
    expect_outs("reset", 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    bus.i_go = 1'b0;
    tick();
    expect_outs("post_reset", 1'b0, 1'b0, 1'b0, '0, '0);

    // Vector 0: the worked N=2 example with hand-derived lanes {beat2, beat1, beat0}.
    vecs[0] = '{a: spec_a, b: spec_b, exp_a: 24'h403201, exp_b: 24'h806705, eom_gap: 4'd4};
    for (int v = 1; v < NV; v++) begin
      rnd = $urandom();
      vecs[v].a = rnd[MW-1:0];
      rnd = $urandom();
      vecs[v].b = rnd[MW-1:0];
      vecs[v].exp_a = pack_a(vecs[v].a);
      vecs[v].exp_b = pack_b(vecs[v].b);
      vecs[v].eom_gap = 4'($urandom_range(1, 10));
    end

    for (int v = 0; v < NV; v++) begin
      load_mats(vecs[v].a, vecs[v].b);
      run_stream($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b);
      finish_with_eom($sformatf("vec%0d", v), int'(vecs[v].eom_gap));
    end

    // LD and EOM during STREAM, GO during WAIT: all ignored.
    load_mats(spec_a, spec_b);
    bus.i_go = 1'b1;
    tick();
    bus.i_go = 1'b0;
    expect_outs("frozen.start", 1'b1, 1'b1, 1'b0, '0, '0);
    bus.i_ld = 1'b1; bus.i_lsel = 1'b0; bus.i_lrow = '0; bus.i_lcol = '0; bus.i_ldat = 4'd9;
    bus.i_eom = 1'b1;
    for (int t = 0; t < NB; t++) begin
      tick();
      expect_outs($sformatf("frozen.beat%0d", t), 1'b0, 1'b1, 1'b0,
                  model_a(spec_a, t), model_b(spec_b, t));
    end
    bus.i_ld = 1'b0;
    bus.i_eom = 1'b0;
    bus.i_go = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_outs($sformatf("go_in_wait%0d", k), 1'b0, 1'b1, 1'b0, '0, '0);
    end
    bus.i_go = 1'b0;
    finish_with_eom("go_in_wait", 2);
    tick();
    expect_outs("go_not_queued", 1'b0, 1'b0, 1'b0, '0, '0);
    run_stream("old_a00", pack_a(spec_a), pack_b(spec_b));
    finish_with_eom("old_a00", 1);

    // GO and LD together in IDLE: the new B[1][1] is streamed.
    b_mod = spec_b;
    b_mod[(1*N+1)*W +: W] = 4'hF;
    bus.i_ld = 1'b1; bus.i_lsel = 1'b1; bus.i_lrow = IW'(1); bus.i_lcol = IW'(1);
    bus.i_ldat = 4'hF;
    run_stream("go_ld", pack_a(spec_a), pack_b(b_mod));
    finish_with_eom("go_ld", 3);

    // Reset mid-run: outputs clear, no DONE, storage cleared to zero.
    bus.i_go = 1'b1;
    tick();
    bus.i_go = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_outs("midrun_reset", 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_outs($sformatf("midrun_no_done%0d", k), 1'b0, 1'b0, 1'b0, '0, '0);
    end
    run_stream("cleared", '0, '0);
    finish_with_eom("cleared", 3);

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog: no EOM, timeout decided in WAIT cycle TMO, ERR sticky until next GO.
    load_mats(spec_a, spec_b);
    run_stream("tmo", pack_a(spec_a), pack_b(spec_b));
    for (int k = 1; k <= TMO_DEF; k++) begin
      tick();
      expect_outs($sformatf("tmo.wait%0d", k), 1'b0, 1'b1, 1'b0, '0, '0);
    end
    exp_err = 1'b1;
    tick();
    expect_outs("tmo.done", 1'b0, 1'b0, 1'b1, '0, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_outs($sformatf("tmo.err_sticky%0d", k), 1'b0, 1'b0, 1'b0, '0, '0);
    end
    exp_err = 1'b0;
    run_stream("tmo_clear", pack_a(spec_a), pack_b(spec_b));
    finish_with_eom("tmo_clear", 2);
`else
    // No watchdog: WAIT persists well beyond the nominal timeout until EOM arrives.
    load_mats(spec_a, spec_b);
    run_stream("no_wdog", pack_a(spec_a), pack_b(spec_b));
    for (int k = 1; k <= 3*TMO_DEF; k++) begin
      tick();
      expect_outs($sformatf("no_wdog.wait%0d", k), 1'b0, 1'b1, 1'b0, '0, '0);
    end
    finish_with_eom("no_wdog", 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
